// File: rtl/xoshiro_prng_fifo.sv
// xoshiro_prng_fifo
//   xoshiro128++ (W=32) or xoshiro256++ (W=64) generator. Words are prefetched into a
//   first-word-fall-through FIFO. A hardware jump engine advances the state by 2^(2W)
//   steps to start a non-overlapping substream.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   write/write_addr/     load state word s[write_addr] (ignored while busy); flushes FIFO
//     write_data
//   jump                  start a jump sequence (ignored while busy); flushes FIFO
//   busy                  high while seeding after reset or while jumping
//   rd_valid/rd_ready/    FIFO head and pop handshake
//     rd_data
//   level                 FIFO occupancy
module xoshiro_prng_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write,
    input  logic [1:0]             write_addr,
    input  logic [W-1:0]           write_data,
    input  logic                   jump,
    output logic                   busy,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned PW     = $clog2(DEPTH);
    localparam int unsigned BW     = $clog2(W);
    localparam int unsigned SW     = BW + 2;  // step counter spans 4*W jump steps
    localparam int unsigned ShiftT = (W == 32) ? 9 : 17;
    localparam int unsigned RotR   = (W == 32) ? 7 : 23;
    localparam int unsigned RotS   = (W == 32) ? 11 : 45;

    typedef enum logic [1:0] {StSeed, StRun, StJump, StCommit} state_e;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int unsigned k);
        return (x << k) | (x >> (W - k));
    endfunction

    function automatic logic [W-1:0] seed_word(input logic [1:0] i);
        logic [63:0] v;
        unique case (i)
            2'd0:    v = (W == 32) ? 64'h0D1929D2 : 64'h0D1929D2491DFB74;
            2'd1:    v = (W == 32) ? 64'h491DFB74 : 64'h473E5E7DD6CA8A07;
            2'd2:    v = (W == 32) ? 64'h473E5E7D : 64'h9E3779B97F4A7C15;
            default: v = (W == 32) ? 64'hD6CA8A07 : 64'hBF58476D1CE4E5B9;
        endcase
        return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] jump_word(input logic [1:0] i);
        logic [63:0] v;
        unique case (i)
            2'd0:    v = (W == 32) ? 64'h8764000B : 64'h180EC6D33CFD0ABA;
            2'd1:    v = (W == 32) ? 64'hF542D2D3 : 64'hD5A61266F0C9392C;
            2'd2:    v = (W == 32) ? 64'h6FA035C3 : 64'hA9582618E03FC9AA;
            default: v = (W == 32) ? 64'h77F2DB5B : 64'h39ABDC4529B1661C;
        endcase
        return v[W-1:0];
    endfunction

    state_e         state_q;
    logic [1:0]     seed_cnt_q;
    logic [SW-1:0]  step_q;
    logic [W-1:0]   s_q   [4];
    logic [W-1:0]   acc_q [4];
    logic [W-1:0]   mem_q [DEPTH];
    logic [PW:0]    wptr_q, rptr_q;

    logic [W-1:0]   s_nxt [4];
    logic [W-1:0]   t, x0, x1, x2, x3, result, jw;
    logic           jump_bit, pop, full, gen;

    // One xoshiro step and the ++ scrambler on the current state
    always_comb begin
        t        = s_q[1] << ShiftT;
        x2       = s_q[2] ^ s_q[0];
        x3       = s_q[3] ^ s_q[1];
        x1       = s_q[1] ^ x2;
        x0       = s_q[0] ^ x3;
        s_nxt[0] = x0;
        s_nxt[1] = x1;
        s_nxt[2] = x2 ^ t;
        s_nxt[3] = rotl(x3, RotS);
        result   = rotl(s_q[0] + s_q[3], RotR) + s_q[0];
    end

    // Step i uses bit (i mod W) of jump word (i / W)
    always_comb begin
        jw       = jump_word(step_q[SW-1:BW]);
        jump_bit = jw[step_q[BW-1:0]];
    end

    // Occupancy comes from the extra pointer bit; pointers wrap modulo DEPTH
    always_comb begin
        level    = wptr_q - rptr_q;
        rd_valid = (level != '0);
        rd_data  = mem_q[rptr_q[PW-1:0]];
        pop      = rd_ready & rd_valid;
        full     = (level == (PW + 1)'(DEPTH));
        gen      = (state_q == StRun) & ~write & ~jump & (~full | pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StSeed;
            seed_cnt_q <= '0;
            step_q     <= '0;
            busy       <= 1'b1;
            wptr_q     <= '0;
            rptr_q     <= '0;
            for (int i = 0; i < 4; i++) begin
                s_q[i]   <= '0;
                acc_q[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // Pops are honoured in every state; a flush below overrides this
            if (pop) begin
                rptr_q <= rptr_q + (PW + 1)'(1);
            end
            unique case (state_q)
                StSeed: begin
                    s_q[seed_cnt_q] <= seed_word(seed_cnt_q);
                    seed_cnt_q      <= seed_cnt_q + 2'd1;
                    if (seed_cnt_q == 2'd3) begin
                        state_q <= StRun;
                        busy    <= 1'b0;
                    end
                end
                StRun: begin
                    if (write) begin
                        s_q[write_addr] <= write_data;
                        rptr_q          <= wptr_q;
                    end else if (jump) begin
                        state_q <= StJump;
                        busy    <= 1'b1;
                        step_q  <= '0;
                        rptr_q  <= wptr_q;
                        for (int i = 0; i < 4; i++) begin
                            acc_q[i] <= '0;
                        end
                    end else if (gen) begin
                        mem_q[wptr_q[PW-1:0]] <= result;
                        wptr_q                <= wptr_q + (PW + 1)'(1);
                        for (int i = 0; i < 4; i++) begin
                            s_q[i] <= s_nxt[i];
                        end
                    end
                end
                StJump: begin
                    for (int i = 0; i < 4; i++) begin
                        if (jump_bit) begin
                            acc_q[i] <= acc_q[i] ^ s_q[i];
                        end
                        s_q[i] <= s_nxt[i];
                    end
                    step_q <= step_q + SW'(1);
                    if (step_q == '1) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    for (int i = 0; i < 4; i++) begin
                        s_q[i] <= acc_q[i];
                    end
                    state_q <= StRun;
                    busy    <= 1'b0;
                end
                default: state_q <= StSeed;
            endcase
        end
    end

endmodule

// File: tb/tb_xoshiro_prng_fifo.sv
// Testbench for xoshiro_prng_fifo: drives a W=32/DEPTH=4 and a W=64/DEPTH=8 instance with
// the same stimulus and compares every cycle against a behavioural model (word queue,
// plain-arithmetic xoshiro, busy countdown).
module tb_xoshiro_prng_fifo;

    logic        clk;
    logic        rst_n;
    logic        write;
    logic [1:0]  waddr;
    logic [63:0] wdata;
    logic        jump;
    logic        rd_ready;

    logic        busy_a, valid_a;
    logic [31:0] data_a;
    logic [2:0]  level_a;
    logic        busy_b, valid_b;
    logic [63:0] data_b;
    logic [3:0]  level_b;

    int n_tests = 0;
    int n_fail  = 0;
    int ca, cb;

    xoshiro_prng_fifo #(.W(32), .DEPTH(4)) u_dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .write_addr (waddr),
        .write_data (wdata[31:0]),
        .jump       (jump),
        .busy       (busy_a),
        .rd_valid   (valid_a),
        .rd_ready   (rd_ready),
        .rd_data    (data_a),
        .level      (level_a)
    );

    xoshiro_prng_fifo #(.W(64), .DEPTH(8)) u_dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .write_addr (waddr),
        .write_data (wdata),
        .jump       (jump),
        .busy       (busy_b),
        .rd_valid   (valid_b),
        .rd_ready   (rd_ready),
        .rd_data    (data_b),
        .level      (level_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (index 0: W=32, index 1: W=64) ----------------
    logic [63:0] ms [2][4];
    logic [63:0] mf [2][16];
    int          mcnt  [2];
    int          mbusy [2];

    function automatic int wid(input int idx);
        return (idx == 0) ? 32 : 64;
    endfunction

    function automatic int dep(input int idx);
        return (idx == 0) ? 4 : 8;
    endfunction

    function automatic logic [63:0] msk(input int idx);
        return (idx == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] rotl_m(input logic [63:0] x, input int k, input int idx);
        logic [63:0] v;
        v = x & msk(idx);
        return ((v << k) | (v >> (wid(idx) - k))) & msk(idx);
    endfunction

    function automatic logic [63:0] seed_c(input int idx, input int j);
        logic [63:0] s32 [4];
        logic [63:0] s64 [4];
        s32 = '{64'h0D1929D2, 64'h491DFB74, 64'h473E5E7D, 64'hD6CA8A07};
        s64 = '{64'h0D1929D2491DFB74, 64'h473E5E7DD6CA8A07,
                64'h9E3779B97F4A7C15, 64'hBF58476D1CE4E5B9};
        return (idx == 0) ? s32[j] : s64[j];
    endfunction

    function automatic logic [63:0] jump_c(input int idx, input int j);
        logic [63:0] j32 [4];
        logic [63:0] j64 [4];
        j32 = '{64'h8764000B, 64'hF542D2D3, 64'h6FA035C3, 64'h77F2DB5B};
        j64 = '{64'h180EC6D33CFD0ABA, 64'hD5A61266F0C9392C,
                64'hA9582618E03FC9AA, 64'h39ABDC4529B1661C};
        return (idx == 0) ? j32[j] : j64[j];
    endfunction

    function automatic logic [63:0] m_out(input int idx);
        int k;
        k = (idx == 0) ? 7 : 23;
        return (rotl_m(ms[idx][0] + ms[idx][3], k, idx) + ms[idx][0]) & msk(idx);
    endfunction

    task automatic m_next(input int idx);
        logic [63:0] t;
        t = (ms[idx][1] << ((idx == 0) ? 9 : 17)) & msk(idx);
        ms[idx][2] = ms[idx][2] ^ ms[idx][0];
        ms[idx][3] = ms[idx][3] ^ ms[idx][1];
        ms[idx][1] = ms[idx][1] ^ ms[idx][2];
        ms[idx][0] = ms[idx][0] ^ ms[idx][3];
        ms[idx][2] = ms[idx][2] ^ t;
        ms[idx][3] = rotl_m(ms[idx][3], (idx == 0) ? 11 : 45, idx);
    endtask

    task automatic m_reset(input int idx);
        for (int j = 0; j < 4; j++) ms[idx][j] = seed_c(idx, j);
        mcnt[idx]  = 0;
        mbusy[idx] = 4;
    endtask

    // The jumped state is not observable until the jump ends, so apply it at once
    task automatic m_jump(input int idx);
        logic [63:0] acc [4];
        int w;
        w = wid(idx);
        for (int j = 0; j < 4; j++) acc[j] = 0;
        for (int i = 0; i < 4 * w; i++) begin
            if (((jump_c(idx, i / w) >> (i % w)) & 64'd1) != 0)
                for (int j = 0; j < 4; j++) acc[j] = acc[j] ^ ms[idx][j];
            m_next(idx);
        end
        for (int j = 0; j < 4; j++) ms[idx][j] = acc[j];
    endtask

    task automatic m_pop(input int idx);
        for (int k = 0; k < 15; k++) mf[idx][k] = mf[idx][k + 1];
        mcnt[idx]--;
    endtask

    task automatic m_tick(input int idx);
        bit p;
        p = rd_ready && (mcnt[idx] > 0);
        if (mbusy[idx] > 0) begin
            if (p) m_pop(idx);
            mbusy[idx]--;
        end else if (write) begin
            ms[idx][waddr] = wdata & msk(idx);
            mcnt[idx] = 0;
        end else if (jump) begin
            mcnt[idx] = 0;
            m_jump(idx);
            mbusy[idx] = 4 * wid(idx) + 1;
        end else begin
            if (p) m_pop(idx);
            if (mcnt[idx] < dep(idx)) begin
                mf[idx][mcnt[idx]] = m_out(idx);
                mcnt[idx]++;
                m_next(idx);
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            m_tick(0);
            m_tick(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_outputs();
        check_eq("busy32",  {63'd0, busy_a},  {63'd0, mbusy[0] > 0});
        check_eq("level32", {61'd0, level_a}, mcnt[0]);
        check_eq("valid32", {63'd0, valid_a}, {63'd0, mcnt[0] > 0});
        if (mcnt[0] > 0) check_eq("data32", {32'd0, data_a}, mf[0][0]);
        check_eq("busy64",  {63'd0, busy_b},  {63'd0, mbusy[1] > 0});
        check_eq("level64", {60'd0, level_b}, mcnt[1]);
        check_eq("valid64", {63'd0, valid_b}, {63'd0, mcnt[1] > 0});
        if (mcnt[1] > 0) check_eq("data64", data_b, mf[1][0]);
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [63:0] d,
                         input logic j, input logic r);
        write    = w;
        waddr    = a;
        wdata    = d;
        jump     = j;
        rd_ready = r;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input int pop_pct);
        for (int i = 0; i < n; i++)
            drive(1'b0, 2'd0, 64'd0, 1'b0, $urandom_range(0, 99) < pop_pct);
    endtask

    task automatic write_seed_1234();
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i), 64'(i + 1), 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        write = 1'b0; waddr = 2'd0; wdata = 64'd0; jump = 1'b0; rd_ready = 1'b0;
        m_reset(0);
        m_reset(1);
        repeat (3) @(negedge clk);
        check_outputs();
        check_eq("rst_busy32", {63'd0, busy_a}, 64'd1);
        check_eq("rst_data32", {32'd0, data_a}, 64'd0);
        check_eq("rst_level64", {60'd0, level_b}, 64'd0);
        rst_n = 1'b1;

        // Seeding then fill without pops
        idle(20, 0);
        check_eq("full32", {61'd0, level_a}, 64'd4);
        check_eq("full64", {60'd0, level_b}, 64'd8);

        // Known-answer words from seed {1,2,3,4}
        drive(1'b1, 2'd0, 64'd1, 1'b0, 1'b1);
        check_eq("wr_flush32", {61'd0, level_a}, 64'd0);
        drive(1'b1, 2'd1, 64'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd2, 64'd3, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 64'd4, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 64'd0, 1'b0, 1'b0);
        check_eq("kat32_0", {32'd0, data_a}, 64'h0000_0281);
        check_eq("kat64_0", data_b, 64'h0000_0000_0280_0001);
        drive(1'b0, 2'd0, 64'd0, 1'b0, 1'b1);
        check_eq("kat32_1", {32'd0, data_a}, 64'h0018_0387);

        // Random pops, then back-to-back pops from a full FIFO
        idle(300, 50);
        idle(10, 0);
        idle(1000, 100);
        check_eq("cont_level32", {61'd0, level_a}, 64'd4);
        check_eq("cont_level64", {60'd0, level_b}, 64'd8);

        // Jump from seed {1,2,3,4}; writes/jumps while busy must be ignored
        write_seed_1234();
        idle(2, 0);
        drive(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);
        ca = 0;
        cb = 0;
        for (int k = 0; k < 400; k++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (!busy_a && !busy_b) break;
            drive(k < 100 && $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                  {$urandom, $urandom}, k < 100 && $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1);
        end
        check_eq("jump_len32", 64'(ca), 64'd129);
        check_eq("jump_len64", 64'(cb), 64'd257);
        idle(200, 60);

        // Write and jump together: write wins
        drive(1'b1, 2'd2, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
        check_eq("wj_busy32", {63'd0, busy_a}, 64'd0);
        check_eq("wj_busy64", {63'd0, busy_b}, 64'd0);
        idle(30, 50);

        // Reset in the middle of a jump (before step 50)
        drive(1'b0, 2'd0, 64'd0, 1'b1, 1'b0);
        idle(50, 0);
        rst_n = 1'b0;
        m_reset(0);
        m_reset(1);
        #1;
        check_outputs();
        check_eq("rstj_busy64", {63'd0, busy_b}, 64'd1);
        check_eq("rstj_valid32", {63'd0, valid_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(40, 50);

        // Random mix
        for (int k = 0; k < 600; k++)
            drive($urandom_range(0, 99) < 2, 2'($urandom_range(0, 3)), {$urandom, $urandom},
                  $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
